// File: rtl/mux_81_if.sv
// Bus bundle for the 8:1 bit multiplexer: data/select in, direct and registered results out.
// The master drives data and select; the slave is the multiplexer itself.
interface mux_81_if;
  logic [7:0] in_i;
  logic [2:0] select_i;
  logic       out_o;
  logic       out_q_o;
  logic [2:0] sel_q_o;
  logic       out_chg_o;

  modport master (
    output in_i, select_i,
    input  out_o, out_q_o, sel_q_o, out_chg_o
  );

  modport slave (
    input  in_i, select_i,
    output out_o, out_q_o, sel_q_o, out_chg_o
  );
endinterface

// File: rtl/mux_81.sv
// 8:1 single-bit multiplexer with a zero-latency output, a registered copy of the
// result and its select index, and a one-cycle pulse whenever the registered bit changes.
module mux_81 (
  input logic     clk_i,
  input logic     rst_i,
  mux_81_if.slave bus
);

  logic       out_q_q, out_q_d;
  logic [2:0] sel_q_q, sel_q_d;
  logic       out_chg_q, out_chg_d;
  logic       mux_out;

  // Pure combinational path: valid with clk/rst tied off, X on select may propagate.
  assign mux_out = bus.in_i[bus.select_i];

  always_comb begin
    out_q_d   = mux_out;
    sel_q_d   = bus.select_i;
    out_chg_d = (mux_out != out_q_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q_q   <= 1'b0;
      sel_q_q   <= 3'b000;
      out_chg_q <= 1'b0;
    end else begin
      out_q_q   <= out_q_d;
      sel_q_q   <= sel_q_d;
      out_chg_q <= out_chg_d;
    end
  end

  assign bus.out_o     = mux_out;
  assign bus.out_q_o   = out_q_q;
  assign bus.sel_q_o   = sel_q_q;
  assign bus.out_chg_o = out_chg_q;

endmodule

// File: tb/tb_mux_81.sv
// Self-checking bench for mux_81: directed and exhaustive combinational checks, then
// clocked directed and random sequences compared against a cycle-level reference model.
module tb_mux_81;

  logic clk;
  logic rst;
  logic run_clk;
  int   checks;
  int   failures;

  // Reference state of the registered outputs
  logic       m_out_q;
  logic [2:0] m_sel_q;
  logic       m_chg;

  mux_81_if bus ();

  mux_81 dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  function automatic logic ref_bit(input logic [7:0] d, input logic [2:0] s);
    int unsigned v;
    v = d;
    return ((v >> s) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clocked step: apply inputs mid-cycle, advance model at the edge, check after it.
  task automatic step(input logic [7:0] d, input logic [2:0] s, input logic r, input string tag);
    logic nb;
    @(negedge clk);
    bus.in_i     = d;
    bus.select_i = s;
    rst          = r;
    #1;
    nb = ref_bit(d, s);
    check({tag, "_out"}, {7'd0, bus.out_o}, {7'd0, nb});
    @(posedge clk);
    if (r) begin
      m_out_q = 1'b0;
      m_sel_q = 3'd0;
      m_chg   = 1'b0;
    end else begin
      m_chg   = (nb != m_out_q);
      m_out_q = nb;
      m_sel_q = s;
    end
    #1;
    check({tag, "_out_q"},   {7'd0, bus.out_q_o},   {7'd0, m_out_q});
    check({tag, "_sel_q"},   {5'd0, bus.sel_q_o},   {5'd0, m_sel_q});
    check({tag, "_out_chg"}, {7'd0, bus.out_chg_o}, {7'd0, m_chg});
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       e;
  } comb_vec_t;

  comb_vec_t sweep[6];

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    run_clk = 1'b0;
    checks = 0;
    failures = 0;
    m_out_q = 1'b0;
    m_sel_q = 3'd0;
    m_chg = 1'b0;

    // Combinational sweep with the clock stopped
    sweep[0] = '{8'b10101010, 3'd0, 1'b0};
    sweep[1] = '{8'b01010101, 3'd4, 1'b1};
    sweep[2] = '{8'b11111111, 3'd2, 1'b1};
    sweep[3] = '{8'b00001111, 3'd3, 1'b1};
    sweep[4] = '{8'b11001100, 3'd6, 1'b1};
    sweep[5] = '{8'b11110000, 3'd5, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus.in_i     = sweep[i].d;
      bus.select_i = sweep[i].s;
      #10;
      check("sweep_out", {7'd0, bus.out_o}, {7'd0, sweep[i].e});
    end

    for (int v = 0; v < 256; v++) begin
      for (int s = 0; s < 8; s++) begin
        bus.in_i     = v[7:0];
        bus.select_i = s[2:0];
        #1;
        check("exh_out", {7'd0, bus.out_o}, {7'd0, ref_bit(v[7:0], s[2:0])});
      end
    end

    run_clk = 1'b1;

    // Reset held with all-ones input: registers clear, direct output stays high
    step(8'hFF, 3'd7, 1'b1, "rst0");
    step(8'hFF, 3'd7, 1'b1, "rst1");

    // Registered latency
    step(8'h01, 3'd0, 1'b0, "lat0");
    step(8'h01, 3'd1, 1'b0, "lat1");
    step(8'h01, 3'd0, 1'b0, "lat2");

    // Drop out_q low, then hold a steady high selection
    step(8'h00, 3'd0, 1'b0, "clr");
    for (int i = 0; i < 5; i++) step(8'hAA, 3'd1, 1'b0, "steady");

    // Mid-stream reset while out_q is high
    step(8'hAA, 3'd1, 1'b1, "mrst");
    step(8'hAA, 3'd1, 1'b0, "mrst_rel");

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(255, 0), $urandom_range(7, 0), ($urandom_range(19, 0) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_81.md
# mux_81

Eight-to-one single-bit multiplexer with a registered copy of its result. Combinational output `out` presents the bit of `in` chosen by `select` with zero latency. Registered outputs give the same result one cycle later for timing-closed downstream logic, plus a change-detect pulse. It sits at datapath leaf level wherever one of eight status or data bits must be picked by a 3-bit index.

## Interface
Parameters:
- none (widths fixed: 8 data inputs, 3-bit select)

Ports:
- `clk`  input  1  single clock; all registers update on its rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in`  input  8  data bits; bit i is selected when `select == i`
- `select`  input  3  index of the bit to route, 0..7
- `out`  output  1  combinational result `in[select]`
- `out_q`  output  1  registered `out`
- `sel_q`  output  3  registered `select`, i.e. the index that produced `out_q`
- `out_chg`  output  1  one-cycle pulse when `out_q` changes value

## Operation
- `out = in[select]` at all times: purely combinational, independent of `clk` and `rst`.
- All eight select codes are legal; there is no error or default case beyond 0..7.
- `out` must be valid with no clock toggling and with `rst` at any level, so a combinational-only environment works with `clk`/`rst` tied off.
- Decoding is a full 8:1 selection: code 3'b000 selects `in[0]` and 3'b111 selects `in[7]`.
- An X or Z on `select` may propagate X to `out`; no gating is applied.
- Registered path, per rising `clk` edge:
  - If `rst` = 1: `out_q` <= 0, `sel_q` <= 0, `out_chg` <= 0.
  - Otherwise: `out_q` <= `out`, `sel_q` <= `select`, `out_chg` <= (`out` != `out_q`).
- `out_chg` compares the new sample against the previous `out_q`.
  - It is never asserted in the cycle reset is applied.
  - On the first edge after reset, it asserts if the sampled `out` is 1.

## Timing
- `out`: zero-cycle latency; settles within combinational delay after any change on `in` or `select`.
- `out_q` and `sel_q`: one-cycle latency; reflect inputs sampled at the previous rising edge.
- `out_chg`: asserted in the same cycle that `out_q` takes its new value; lasts exactly one cycle per change.
- Reset values: `out_q` = 0, `sel_q` = 3'b000, `out_chg` = 0. `out` has no reset value; it follows its inputs.
- Reset asserted mid-stream: registered outputs clear at that edge. `out` is unaffected.
- Simultaneous change of `in` and `select`: `out` reflects the new pair only. No glitch-free guarantee on `out`; `out_q` is glitch-free.

## Test plan
- Combinational sweep, no clock, 10 time units per step; each `in`/`select` pair -> `out`:
  - 8'b10101010 / 0 -> 0
  - 8'b01010101 / 4 -> 1
  - 8'b11111111 / 2 -> 1
  - 8'b00001111 / 3 -> 1
  - 8'b11001100 / 6 -> 1
  - 8'b11110000 / 5 -> 1
- Exhaustive: for all 256 `in` values × 8 `select` codes -> `out == in[select]`.
- Reset: hold `rst` = 1 for 2 cycles with `in` = 8'hFF, `select` = 7 -> `out_q` = 0, `sel_q` = 0, `out_chg` = 0, while `out` = 1 throughout.
- Registered latency: release reset, apply `in` = 8'h01 with `select` = 0, then 1, then 0 on consecutive cycles:
  - `out_q` sequence 1, 0, 1, each one cycle after the input.
  - `sel_q` tracks the select codes 0, 1, 0, one cycle late.
  - `out_chg` pulses 1, 1, 1.
- Steady input: hold `in` = 8'hAA, `select` = 1 for 5 cycles -> `out_q` = 1; `out_chg` = 1 only on the first cycle, 0 thereafter.
- Mid-stream reset: with `out_q` = 1, assert `rst` for one cycle -> `out_q` = 0 and `out_chg` = 0 at that edge. On the next edge, with `out` still 1 -> `out_q` = 1 and `out_chg` = 1.
